// File: rtl/ram_rd_burst_pkg.sv
// Shared types and default widths for the burst read-request generator.
package ram_rd_burst_pkg;

  localparam int unsigned DEF_ADD_W = 8;
  localparam int unsigned DEF_LEN_W = 8;
  localparam int unsigned DEF_ID_W  = 4;
  localparam int unsigned DEF_SIDE_W = DEF_ID_W + 2;

  typedef struct packed {
    logic [DEF_ID_W-1:0] id;
    logic                first;
    logic                last;
  } side_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_element.sv
// Small rdy/vld FIFO stage; TYPE_ARRAY bit 1 selects a flopped input ready (low through reset).
module fifo_element #(
  parameter int unsigned W          = 8,
  parameter int unsigned DEPTH      = 2,
  parameter logic [7:0]  TYPE_ARRAY = 8'h12
) (
  input  logic         clk,
  input  logic         s_rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam bit          REG_RDY = TYPE_ARRAY[1];

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push     = in_vld & in_rdy;
  assign pop      = out_vld & out_rdy;
  assign out_vld  = (cnt_q != '0);
  assign out_data = mem_q[rd_ptr_q];
  assign cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  if (REG_RDY) begin : g_reg_rdy
    logic rdy_q;
    always_ff @(posedge clk) begin
      if (!s_rst_n) rdy_q <= 1'b0;
      else          rdy_q <= (cnt_d != CNT_W'(DEPTH));
    end
    assign in_rdy = rdy_q;
  end else begin : g_comb_rdy
    assign in_rdy = (cnt_q != CNT_W'(DEPTH));
  end

endmodule

// File: rtl/ram_rd_burst_req.sv
// Expands {addr, len, id} burst commands into one wrapped read request per cycle,
// tagging each request with {id, first, last}.
module ram_rd_burst_req
  import ram_rd_burst_pkg::*;
#(
  parameter bit          CMD_IN_PIPE = 1'b1,
  parameter int unsigned ADD_W       = DEF_ADD_W,
  parameter int unsigned RAM_DEPTH   = 2 ** ADD_W,
  parameter int unsigned LEN_W       = DEF_LEN_W,
  parameter int unsigned ID_W        = DEF_ID_W,
  localparam int unsigned SIDE_W     = ID_W + 2
) (
  input  logic              clk,
  input  logic              s_rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADD_W-1:0]  cmd_add,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ID_W-1:0]   cmd_id,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic [ADD_W-1:0]  rd_add,
  output logic [SIDE_W-1:0] rd_side,
  output logic              busy
);

  localparam int unsigned      CMD_W    = ADD_W + LEN_W + ID_W;
  localparam logic [0:0]       S_IDLE   = 1'(IDLE);
  localparam logic [0:0]       S_BURST  = 1'(BURST);
  localparam logic [ADD_W-1:0] ADD_LAST = ADD_W'(RAM_DEPTH - 1);

  logic             c_vld;
  logic             c_rdy_c;
  logic [CMD_W-1:0] c_data;
  logic [ADD_W-1:0] c_add;
  logic [LEN_W-1:0] c_len;
  logic [ID_W-1:0]  c_id;
  logic             pipe_vld;

  logic [0:0]       state_q, state_d;
  logic [ADD_W-1:0] add_q, add_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             load;

  if (CMD_IN_PIPE) begin : g_pipe
    fifo_element #(
      .W          (CMD_W),
      .DEPTH      (2),
      .TYPE_ARRAY (8'h12)
    ) u_cmd_pipe (
      .clk      (clk),
      .s_rst_n  (s_rst_n),
      .in_vld   (cmd_vld),
      .in_rdy   (cmd_rdy),
      .in_data  ({cmd_add, cmd_len, cmd_id}),
      .out_vld  (c_vld),
      .out_rdy  (c_rdy_c),
      .out_data (c_data)
    );
    assign pipe_vld = c_vld;
  end else begin : g_direct
    assign c_vld    = cmd_vld;
    assign cmd_rdy  = c_rdy_c;
    assign c_data   = {cmd_add, cmd_len, cmd_id};
    assign pipe_vld = 1'b0;
  end

  assign {c_add, c_len, c_id} = c_data;

  // A new command may enter while idle or alongside the handshake of the final beat.
  assign c_rdy_c = (state_q == S_IDLE) | (rd_vld & rd_rdy & last_q);

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_q <= S_IDLE;
      add_q   <= '0;
      rem_q   <= '0;
      id_q    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      add_q   <= add_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    add_d   = add_q;
    rem_d   = rem_q;
    id_d    = id_q;
    first_d = first_q;
    last_d  = last_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c_vld) begin
          load    = 1'b1;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (rd_rdy) begin
          if (!last_q) begin
            add_d   = (add_q == ADD_LAST) ? '0 : add_q + ADD_W'(1);
            rem_d   = rem_q - LEN_W'(1);
            first_d = 1'b0;
            last_d  = (rem_q == LEN_W'(1));
          end else if (c_vld) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      add_d   = c_add;
      rem_d   = c_len;
      id_d    = c_id;
      first_d = 1'b1;
      last_d  = (c_len == '0);
    end
  end

  assign rd_vld  = (state_q == S_BURST);
  assign rd_add  = add_q;
  assign rd_side = {id_q, first_q, last_q};
  assign busy    = (state_q == S_BURST) | pipe_vld;

`ifndef SYNTHESIS
  logic              chk_stall;
  logic [ADD_W-1:0]  chk_add;
  logic [SIDE_W-1:0] chk_side;

  always_ff @(posedge clk) begin
    chk_stall <= s_rst_n & rd_vld & ~rd_rdy;
    chk_add   <= rd_add;
    chk_side  <= rd_side;
    if (s_rst_n && c_vld && c_rdy_c && (32'(c_add) >= RAM_DEPTH))
      $fatal(1, "ram_rd_burst_req: command address %0d outside RAM depth %0d", c_add, RAM_DEPTH);
    if (s_rst_n && chk_stall && ((rd_add != chk_add) || (rd_side != chk_side)))
      $fatal(1, "ram_rd_burst_req: request changed while stalled");
  end
`endif

endmodule
